pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipeline_hazard_ctrl_if.sv | 34 +++
 rtl/sat_counter.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 91 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    localparam int CNT_W_DEFAULT = 16;

    // A load in EX feeding an operand the ID instruction actually reads; x0 never forwards.
    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       use_rs1,
        input logic [4:0] rs2,
        input logic       use_rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - ID/EX hazard inputs and pipeline control outputs
interface pipeline_hazard_ctrl_if;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       useRs1_id;
    logic       useRs2_id;
    logic [4:0] rd_ex;
    logic       memRead_ex;
    logic       mdOp_ex;
    logic       md_done;
    logic       branchTaken_ex;

    logic       stall_pc;
    logic       stall_ifid;
    logic       stall_idex;
    logic       flush_ifid;
    logic       flush_idex;
    logic       bubble_exmem;
    logic       md_start;

    modport master (
        output rs1_id, rs2_id, useRs1_id, useRs2_id, rd_ex, memRead_ex,
               mdOp_ex, md_done, branchTaken_ex,
        input  stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex,
               bubble_exmem, md_start
    );

    modport slave (
        input  rs1_id, rs2_id, useRs1_id, useRs2_id, rd_ex, memRead_ex,
               mdOp_ex, md_done, branchTaken_ex,
        output stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex,
               bubble_exmem, md_start
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous active-low reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/bubble control for load-use, taken branch and mul/div
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    state_e state_q;
    state_e state_d;
    logic   luh;

    assign luh = load_use(hz.memRead_ex, hz.rd_ex, hz.rs1_id, hz.useRs1_id,
                          hz.rs2_id, hz.useRs2_id);

    always_comb begin
        state_d         = state_q;
        hz.stall_pc     = 1'b0;
        hz.stall_ifid   = 1'b0;
        hz.stall_idex   = 1'b0;
        hz.flush_ifid   = 1'b0;
        hz.flush_idex   = 1'b0;
        hz.bubble_exmem = 1'b0;
        hz.md_start     = 1'b0;

        if (!rst_n) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    // Branch wins over everything: the ID/EX contents are wrong-path anyway.
                    if (hz.branchTaken_ex) begin
                        hz.flush_ifid = 1'b1;
                        hz.flush_idex = 1'b1;
                    end else if (hz.mdOp_ex) begin
                        hz.md_start     = 1'b1;
                        hz.stall_pc     = 1'b1;
                        hz.stall_ifid   = 1'b1;
                        hz.stall_idex   = 1'b1;
                        hz.bubble_exmem = 1'b1;
                        state_d         = MD_WAIT;
                    end else if (luh) begin
                        hz.stall_pc   = 1'b1;
                        hz.stall_ifid = 1'b1;
                        hz.flush_idex = 1'b1;
                    end
                end
                MD_WAIT: begin
                    // Holding until the result is valid; releasing in the done cycle lets it advance.
                    if (hz.md_done) begin
                        state_d = RUN;
                    end else begin
                        hz.stall_pc     = 1'b1;
                        hz.stall_ifid   = 1'b1;
                        hz.stall_idex   = 1'b1;
                        hz.bubble_exmem = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hz.stall_pc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hz.flush_ifid),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] stall_cycles, flush_count;
    logic [3:0]  stall_cycles4, flush_count4;

    int n_chk  = 0;
    int n_pass = 0;

    pipeline_hazard_ctrl_if hif ();
    pipeline_hazard_ctrl_if hif4 ();

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hz           (hif.slave),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .hz           (hif4.slave),
        .stall_cycles (stall_cycles4),
        .flush_count  (flush_count4)
    );

    assign hif4.rs1_id         = hif.rs1_id;
    assign hif4.rs2_id         = hif.rs2_id;
    assign hif4.useRs1_id      = hif.useRs1_id;
    assign hif4.useRs2_id      = hif.useRs2_id;
    assign hif4.rd_ex          = hif.rd_ex;
    assign hif4.memRead_ex     = hif.memRead_ex;
    assign hif4.mdOp_ex        = hif.mdOp_ex;
    assign hif4.md_done        = hif.md_done;
    assign hif4.branchTaken_ex = hif.branchTaken_ex;

    // {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, bubble_exmem, md_start}
    function automatic logic [6:0] ctrl();
        return {hif.stall_pc, hif.stall_ifid, hif.stall_idex, hif.flush_ifid,
                hif.flush_idex, hif.bubble_exmem, hif.md_start};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        hif.rs1_id = 5'd0; hif.rs2_id = 5'd0; hif.useRs1_id = 1'b0; hif.useRs2_id = 1'b0;
        hif.rd_ex = 5'd0; hif.memRead_ex = 1'b0; hif.mdOp_ex = 1'b0;
        hif.md_done = 1'b0; hif.branchTaken_ex = 1'b0;
    endtask

    task automatic set_luh();
        hif.memRead_ex = 1'b1; hif.rd_ex = 5'd5; hif.rs1_id = 5'd5; hif.useRs1_id = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        hif.mdOp_ex = 1'b1;
        @(negedge clk);
        check("reset_ctrl_zero", 32'(ctrl()), 32'h0);
        cyc();
        cyc();
        check("reset_stall_cnt", 32'(stall_cycles), 32'd0);
        check("reset_flush_cnt", 32'(flush_count), 32'd0);

        rst_n = 1'b1;
        hif.mdOp_ex = 1'b0;
        @(negedge clk);
        check("idle_ctrl", 32'(ctrl()), 32'h0);
        cyc();

        set_luh();
        @(negedge clk);
        check("luh_ctrl", 32'(ctrl()), 32'(7'b1100100));
        cyc();
        clear_in();
        @(negedge clk);
        check("luh_one_cycle", 32'(ctrl()), 32'h0);
        check("luh_stall_cnt", 32'(stall_cycles), 32'd1);

        hif.memRead_ex = 1'b1; hif.rd_ex = 5'd0; hif.rs1_id = 5'd0; hif.useRs1_id = 1'b1;
        @(negedge clk);
        check("x0_no_hazard", 32'(ctrl()), 32'h0);
        cyc();
        clear_in();
        hif.memRead_ex = 1'b1; hif.rd_ex = 5'd7; hif.rs2_id = 5'd7; hif.useRs2_id = 1'b0;
        @(negedge clk);
        check("unused_rs2", 32'(ctrl()), 32'h0);
        cyc();
        clear_in();

        set_luh();
        hif.branchTaken_ex = 1'b1;
        @(negedge clk);
        check("branch_prio", 32'(ctrl()), 32'(7'b0001100));
        cyc();
        clear_in();
        @(negedge clk);
        check("branch_flush_cnt", 32'(flush_count), 32'd1);
        check("branch_stall_cnt", 32'(stall_cycles), 32'd1);

        hif.md_done = 1'b1;
        @(negedge clk);
        check("md_done_in_run", 32'(ctrl()), 32'h0);
        cyc();
        clear_in();

        hif.mdOp_ex = 1'b1;
        @(negedge clk);
        check("md_launch", 32'(ctrl()), 32'(7'b1110011));
        for (int i = 0; i < 4; i++) begin
            cyc();
            hif.branchTaken_ex = (i == 0);
            @(negedge clk);
            check($sformatf("md_wait_%0d", i), 32'(ctrl()), 32'(7'b1110010));
        end
        cyc();
        hif.branchTaken_ex = 1'b0;
        hif.md_done = 1'b1;
        @(negedge clk);
        check("md_release", 32'(ctrl()), 32'h0);
        cyc();
        hif.md_done = 1'b0;
        @(negedge clk);
        check("md_stall_cnt", 32'(stall_cycles), 32'd6);
        check("md_back_to_back", 32'(ctrl()), 32'(7'b1110011));
        cyc();
        @(negedge clk);
        check("md_no_double_start", 32'({31'd0, hif.md_start}), 32'd0);
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_wait_ctrl", 32'(ctrl()), 32'h0);
        cyc();
        rst_n = 1'b1;
        hif.mdOp_ex = 1'b0;
        @(negedge clk);
        check("rst_release_ctrl", 32'(ctrl()), 32'h0);
        check("rst_release_stall_cnt", 32'(stall_cycles), 32'd0);
        check("rst_release_flush_cnt", 32'(flush_count), 32'd0);
        cyc();

        set_luh();
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (i == 14) begin
                check("sat_reach_15", 32'(stall_cycles4), 32'd15);
            end
        end
        clear_in();
        @(negedge clk);
        check("sat_hold_15", 32'(stall_cycles4), 32'd15);
        check("wide_cnt_20", 32'(stall_cycles), 32'd20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
